// File: rtl/esc_pwm_generator_pkg.sv
// -----------------------------------------------------------------------------
// esc_pwm_generator_pkg
// Shared definitions for the ESC PWM generator: motor-rate width, default
// pulse/frame timing, FSM state encodings, and the rate-to-width helper.
// -----------------------------------------------------------------------------
package esc_pwm_generator_pkg;

    localparam int MOTOR_RATE_BIT_WIDTH = 8;

    // Default timing (parameter defaults for the generator)
    localparam int ESC_CLK_TICKS_PER_US = 38;
    localparam int ESC_FRAME_US         = 2500;
    localparam int ESC_MIN_PULSE_US     = 1000;
    localparam int ESC_MAX_PULSE_US     = 2000;
    localparam int ESC_ARM_FRAMES       = 400;

    localparam int FRAME_US_W = 12;
    localparam int WIDTH_W    = 11;

    // Arming FSM encodings; anything else is treated as an illegal state
    localparam logic [1:0] ST_ARMING = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;

    typedef logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_t;
    typedef logic [WIDTH_W-1:0]              width_t;
    typedef logic [FRAME_US_W-1:0]           frame_us_t;

    // Pulse width in microseconds: min + 4*rate, clamped to [min, max].
    // Computed one bit wider so that the sum can never wrap.
    function automatic width_t esc_width(input rate_t  rate,
                                         input width_t min_us,
                                         input width_t max_us);
        logic [WIDTH_W:0] raw;
        raw = {1'b0, min_us} + {{(WIDTH_W - MOTOR_RATE_BIT_WIDTH - 1){1'b0}}, rate, 2'b00};
        if (raw > {1'b0, max_us}) begin
            esc_width = max_us;
        end else if (raw < {1'b0, min_us}) begin
            esc_width = min_us;
        end else begin
            esc_width = raw[WIDTH_W-1:0];
        end
    endfunction

endpackage

// File: rtl/esc_pwm_generator_if.sv
// -----------------------------------------------------------------------------
// esc_pwm_generator_if
// Bundle between the motor mixer / motor pins and the ESC PWM generator.
//   enable, motor_n_rate       : mixer -> generator
//   motor_n_pwm, frame_start,
//   armed                      : generator -> pins / system
// master: the side driving rates (mixer, testbench); slave: the generator.
// -----------------------------------------------------------------------------
interface esc_pwm_generator_if;
    import esc_pwm_generator_pkg::*;

    logic  enable;
    rate_t motor_1_rate;
    rate_t motor_2_rate;
    rate_t motor_3_rate;
    rate_t motor_4_rate;
    logic  motor_1_pwm;
    logic  motor_2_pwm;
    logic  motor_3_pwm;
    logic  motor_4_pwm;
    logic  frame_start;
    logic  armed;

    modport master (
        output enable, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        input  motor_1_pwm, motor_2_pwm, motor_3_pwm, motor_4_pwm, frame_start, armed
    );

    modport slave (
        input  enable, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        output motor_1_pwm, motor_2_pwm, motor_3_pwm, motor_4_pwm, frame_start, armed
    );

endinterface

// File: rtl/esc_pwm_generator_channel.sv
// -----------------------------------------------------------------------------
// esc_pwm_generator_channel
// One ESC output: converts a rate into a pulse width, holds it in a shadow
// register that reloads only on the frame boundary, and drives the registered
// pulse by comparing the shared microsecond frame counter against it.
//   clk_i, resetn_i : clock, synchronous active-low reset
//   rate_i          : motor rate from mixer
//   load_i          : frame boundary strobe (shadow reload)
//   force_min_i     : latch the minimum width instead of the rate width
//   frame_us_i      : microsecond position inside the current frame
//   pwm_o           : registered ESC pulse
// -----------------------------------------------------------------------------
module esc_pwm_generator_channel
    import esc_pwm_generator_pkg::*;
#(
    parameter int MIN_PULSE_US = ESC_MIN_PULSE_US,
    parameter int MAX_PULSE_US = ESC_MAX_PULSE_US
) (
    input  logic      clk_i,
    input  logic      resetn_i,
    input  rate_t     rate_i,
    input  logic      load_i,
    input  logic      force_min_i,
    input  frame_us_t frame_us_i,
    output logic      pwm_o
);

    localparam width_t MIN_W = width_t'(MIN_PULSE_US);
    localparam width_t MAX_W = width_t'(MAX_PULSE_US);

    width_t shadow_q;
    width_t shadow_d;
    width_t width_s;
    logic   pwm_q;
    logic   pwm_d;

    // Shadow next-state: changes only on the boundary so a running pulse is untouched
    always_comb begin
        width_s  = esc_width(rate_i, MIN_W, MAX_W);
        shadow_d = shadow_q;
        if (!load_i) begin
            shadow_d = shadow_q;
        end else if (force_min_i) begin
            shadow_d = MIN_W;
        end else begin
            shadow_d = width_s;
        end
        pwm_d = (frame_us_i < {1'b0, shadow_q});
    end

    // Shadow width and registered pulse output
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            shadow_q <= MIN_W;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_generator.sv
// -----------------------------------------------------------------------------
// esc_pwm_generator
// Four-channel servo-style ESC PWM generator. A prescaler produces one tick
// per microsecond, a frame counter spans FRAME_US microseconds, and every
// channel reloads its pulse width only at the frame boundary.
//   sys_clk     : system clock
//   resetn      : synchronous active-low reset
//   bus (slave) : enable, motor_1..4_rate in; motor_1..4_pwm, frame_start,
//                 armed out (all outputs registered)
// Build option ESC_ARM_DELAY_EN: when defined, outputs are held at the
// minimum pulse for ARM_FRAMES frames after reset (ARMING state) before
// rates are honoured; when undefined, the block runs from reset.
// -----------------------------------------------------------------------------
module esc_pwm_generator
    import esc_pwm_generator_pkg::*;
#(
    parameter int CLK_TICKS_PER_US = ESC_CLK_TICKS_PER_US,
    parameter int FRAME_US         = ESC_FRAME_US,
    parameter int MIN_PULSE_US     = ESC_MIN_PULSE_US,
    parameter int MAX_PULSE_US     = ESC_MAX_PULSE_US
`ifdef ESC_ARM_DELAY_EN
    ,
    parameter int ARM_FRAMES       = ESC_ARM_FRAMES
`endif
) (
    input  logic                 sys_clk,
    input  logic                 resetn,
    esc_pwm_generator_if.slave   bus
);

    localparam int               DIV_W      = (CLK_TICKS_PER_US > 1) ? $clog2(CLK_TICKS_PER_US) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_TICKS_PER_US - 1);
    localparam frame_us_t        FRAME_LAST = frame_us_t'(FRAME_US - 1);

    logic [DIV_W-1:0] us_div_q;
    logic [DIV_W-1:0] us_div_d;
    frame_us_t        frame_us_q;
    frame_us_t        frame_us_d;
    logic             us_tick_s;
    logic             boundary_s;
    logic             force_min_s;
    logic             frame_start_q;
    logic             armed_q;
    logic             armed_d;
    rate_t            rate_s [4];
    logic [3:0]       pwm_s;

    // Microsecond prescaler and frame position next-state
    always_comb begin
        us_tick_s  = (us_div_q == DIV_LAST);
        boundary_s = us_tick_s && (frame_us_q == FRAME_LAST);
        if (us_tick_s) begin
            us_div_d = {DIV_W{1'b0}};
        end else begin
            us_div_d = us_div_q + DIV_W'(1);
        end
        if (boundary_s) begin
            frame_us_d = {FRAME_US_W{1'b0}};
        end else if (us_tick_s) begin
            frame_us_d = frame_us_q + 12'd1;
        end else begin
            frame_us_d = frame_us_q;
        end
    end

`ifdef ESC_ARM_DELAY_EN
    localparam int               ARM_W    = $clog2(ARM_FRAMES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [ARM_W-1:0] arm_cnt_q;
    logic [ARM_W-1:0] arm_cnt_d;

    // Arming FSM: counts boundaries; the last arming boundary already uses rates
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        force_min_s = 1'b1;
        case (state_q)
            ST_ARMING: begin
                if (boundary_s && (arm_cnt_q == ARM_LAST)) begin
                    state_d     = ST_RUN;
                    force_min_s = !bus.enable;
                end else if (boundary_s) begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end else begin
                    arm_cnt_d = arm_cnt_q;
                end
            end
            ST_RUN: begin
                force_min_s = !bus.enable;
            end
            default: begin
                state_d   = ST_ARMING;
                arm_cnt_d = {ARM_W{1'b0}};
            end
        endcase
        armed_d = (state_d == ST_RUN);
    end

    // Arming FSM state and boundary counter
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state_q   <= ST_ARMING;
            arm_cnt_q <= {ARM_W{1'b0}};
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end
`else
    // Without an arming delay only enable holds the outputs at minimum
    always_comb begin
        force_min_s = !bus.enable;
        armed_d     = 1'b1;
    end
`endif

    // Timebase counters and registered status strobes
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            us_div_q      <= {DIV_W{1'b0}};
            frame_us_q    <= {FRAME_US_W{1'b0}};
            frame_start_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            us_div_q      <= us_div_d;
            frame_us_q    <= frame_us_d;
            frame_start_q <= boundary_s;
            armed_q       <= armed_d;
        end
    end

    assign rate_s[0] = bus.motor_1_rate;
    assign rate_s[1] = bus.motor_2_rate;
    assign rate_s[2] = bus.motor_3_rate;
    assign rate_s[3] = bus.motor_4_rate;

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        esc_pwm_generator_channel #(
            .MIN_PULSE_US (MIN_PULSE_US),
            .MAX_PULSE_US (MAX_PULSE_US)
        ) u_channel (
            .clk_i       (sys_clk),
            .resetn_i    (resetn),
            .rate_i      (rate_s[ch]),
            .load_i      (boundary_s),
            .force_min_i (force_min_s),
            .frame_us_i  (frame_us_q),
            .pwm_o       (pwm_s[ch])
        );
    end

    assign bus.motor_1_pwm = pwm_s[0];
    assign bus.motor_2_pwm = pwm_s[1];
    assign bus.motor_3_pwm = pwm_s[2];
    assign bus.motor_4_pwm = pwm_s[3];
    assign bus.frame_start = frame_start_q;
    assign bus.armed       = armed_q;

endmodule

// File: tb/tb_esc_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_esc_pwm_generator
// Self-checking bench. A per-frame vector table (inputs applied mid-frame,
// expected pulse widths of the following frame) drives the DUT; a cycle-level
// reference model, expressed as position-in-frame arithmetic, predicts every
// output each cycle. Hand-written sequences cover reset and reset mid-pulse.
// -----------------------------------------------------------------------------
module tb_esc_pwm_generator;
    import esc_pwm_generator_pkg::*;

    localparam int T      = 2;
    localparam int FUS    = 2500;
    localparam int FC     = T * FUS;
    localparam int MIN_US = 1000;
    localparam int MAX_US = 2000;
`ifdef ESC_ARM_DELAY_EN
    localparam int ARM_FRAMES = 3;
`endif

    typedef struct packed {
        logic             en;
        logic [3:0][7:0]  rate;
        logic [3:0][11:0] exp_us;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int k;
    int nbound;
    int cur_w  [4];
    int next_w [4];
    int high_cnt [4];
    int mis_cnt;
    int first_mis;

    vec_t vecs [$];

    esc_pwm_generator_if bus ();

    esc_pwm_generator #(
        .CLK_TICKS_PER_US (T),
        .FRAME_US         (FUS),
        .MIN_PULSE_US     (MIN_US),
        .MAX_PULSE_US     (MAX_US)
`ifdef ESC_ARM_DELAY_EN
        ,
        .ARM_FRAMES       (ARM_FRAMES)
`endif
    ) dut (
        .sys_clk (clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int ref_us(input logic en, input int rate);
        int w;
        if (!en) return MIN_US;
        w = MIN_US + 4 * rate;
        return (w > MAX_US) ? MAX_US : w;
    endfunction

    function automatic logic rates_allowed(input int boundary_no);
`ifdef ESC_ARM_DELAY_EN
        return boundary_no >= ARM_FRAMES;
`else
        return boundary_no >= 1;
`endif
    endfunction

    function automatic logic exp_armed_now();
`ifdef ESC_ARM_DELAY_EN
        return nbound >= ARM_FRAMES;
`else
        return k >= 1;
`endif
    endfunction

    function automatic int rate_of(input int ch);
        case (ch)
            0:       return int'(bus.motor_1_rate);
            1:       return int'(bus.motor_2_rate);
            2:       return int'(bus.motor_3_rate);
            default: return int'(bus.motor_4_rate);
        endcase
    endfunction

    function automatic logic [3:0] pwm_vec();
        return {bus.motor_4_pwm, bus.motor_3_pwm, bus.motor_2_pwm, bus.motor_1_pwm};
    endfunction

    function automatic vec_t mk(input logic en, input int r1, input int r2, input int r3, input int r4,
                                input int e1, input int e2, input int e3, input int e4);
        vec_t v;
        v.en        = en;
        v.rate[0]   = 8'(r1);
        v.rate[1]   = 8'(r2);
        v.rate[2]   = 8'(r3);
        v.rate[3]   = 8'(r4);
        v.exp_us[0] = 12'(e1);
        v.exp_us[1] = 12'(e2);
        v.exp_us[2] = 12'(e3);
        v.exp_us[3] = 12'(e4);
        return v;
    endfunction

    function automatic vec_t mk_rand();
        logic en;
        int   r [4];
        en = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 255));
        return mk(en, r[0], r[1], r[2], r[3],
                  ref_us(en, r[0]), ref_us(en, r[1]), ref_us(en, r[2]), ref_us(en, r[3]));
    endfunction

    task automatic drive(input vec_t v);
        bus.enable       = v.en;
        bus.motor_1_rate = v.rate[0];
        bus.motor_2_rate = v.rate[1];
        bus.motor_3_rate = v.rate[2];
        bus.motor_4_rate = v.rate[3];
    endtask

    task automatic model_reset();
        k      = 0;
        nbound = 0;
        for (int i = 0; i < 4; i++) begin
            cur_w[i]  = MIN_US;
            next_w[i] = MIN_US;
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs mid-cycle
    task automatic tick();
        int         pos;
        logic [3:0] exp_pwm;
        logic [3:0] act;
        logic       exp_fs;
        @(posedge clk);
        k++;
        pos = (k - 1) % FC;
        if (pos == 0) cur_w = next_w;
        if (pos == FC - 1) begin
            nbound++;
            for (int i = 0; i < 4; i++)
                next_w[i] = rates_allowed(nbound) ? ref_us(bus.enable, rate_of(i)) : MIN_US;
        end
        @(negedge clk);
        act = pwm_vec();
        for (int i = 0; i < 4; i++) begin
            exp_pwm[i] = (pos < cur_w[i] * T);
            if (act[i]) high_cnt[i]++;
        end
        exp_fs = (pos == FC - 1);
        if ({act, bus.frame_start, bus.armed} !== {exp_pwm, exp_fs, exp_armed_now()}) begin
            if (mis_cnt == 0) first_mis = pos;
            mis_cnt++;
        end
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 4; i++) high_cnt[i] = 0;
        mis_cnt   = 0;
        first_mis = -1;
    endtask

    // Run one full frame, optionally applying the next vector at frame_us = 500
    task automatic run_frame(input string tag, input logic [3:0][11:0] exp_us,
                             input bit apply, input vec_t v);
        clear_tally();
        for (int c = 0; c < FC; c++) begin
            tick();
            if (k == 1) begin
                check({tag, " first cycle pwm"}, 32'(pwm_vec()), 32'hF);
`ifdef ESC_ARM_DELAY_EN
                check({tag, " first cycle armed"}, 32'(bus.armed), 32'd0);
`else
                check({tag, " first cycle armed"}, 32'(bus.armed), 32'd1);
`endif
            end
            if (apply && c == 1000) drive(v);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("%s ch%0d high cycles", tag, i + 1), 32'(high_cnt[i]), 32'(exp_us[i] * T));
        check($sformatf("%s cycles off model (first pos %0d)", tag, first_mis), 32'(mis_cnt), 32'd0);
    endtask

    initial begin
        vec_t             dummy;
        logic [3:0][11:0] all_min;
        dummy   = mk(1'b0, 0, 0, 0, 0, MIN_US, MIN_US, MIN_US, MIN_US);
        all_min = dummy.exp_us;

        // Vector table: inputs presented mid-frame f, expected widths of frame f+1
`ifdef ESC_ARM_DELAY_EN
        for (int i = 0; i < ARM_FRAMES - 1; i++)
            vecs.push_back(mk(1'b1, 200, 200, 200, 200, 1000, 1000, 1000, 1000));
`endif
        vecs.push_back(mk(1'b1, 200, 200, 200, 200, 1800, 1800, 1800, 1800));
        vecs.push_back(mk(1'b1,   0, 128, 249, 255, 1000, 1512, 1996, 2000));
        vecs.push_back(mk(1'b1, 250,   1, 127, 254, 2000, 1004, 1508, 2000));
        vecs.push_back(mk(1'b1,   0,   0,   0,   0, 1000, 1000, 1000, 1000));
        vecs.push_back(mk(1'b1, 255, 255, 255, 255, 2000, 2000, 2000, 2000));
        vecs.push_back(mk(1'b0, 255, 255, 255, 255, 1000, 1000, 1000, 1000));
        vecs.push_back(mk(1'b1, 255, 255, 255, 255, 2000, 2000, 2000, 2000));
        vecs.push_back(mk(1'b0,   7, 250, 100,   3, 1000, 1000, 1000, 1000));
        vecs.push_back(mk_rand());
        vecs.push_back(mk_rand());
        vecs.push_back(mk(1'b1, 255, 255, 255, 255, 2000, 2000, 2000, 2000));

        // Reset held for 5 cycles
        resetn = 1'b0;
        drive(dummy);
        repeat (5) @(negedge clk);
        check("reset pwm", 32'(pwm_vec()), 32'd0);
        check("reset frame_start", 32'(bus.frame_start), 32'd0);
        check("reset armed", 32'(bus.armed), 32'd0);

        resetn = 1'b1;
        model_reset();
        run_frame("frame0", all_min, 1'b1, vecs[0]);
        for (int f = 1; f <= vecs.size(); f++) begin
            if (f < vecs.size())
                run_frame($sformatf("frame%0d", f), vecs[f-1].exp_us, 1'b1, vecs[f]);
            else
                run_frame($sformatf("frame%0d", f), vecs[f-1].exp_us, 1'b0, dummy);
        end

        // Reset mid-pulse at frame_us = 1500 while all outputs are high
        clear_tally();
        for (int c = 0; c < 3000; c++) tick();
        check("pre-reset cycles off model", 32'(mis_cnt), 32'd0);
        check("pre-reset pwm high", 32'(pwm_vec()), 32'hF);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-pulse reset pwm", 32'(pwm_vec()), 32'd0);
        check("mid-pulse reset frame_start", 32'(bus.frame_start), 32'd0);
        check("mid-pulse reset armed", 32'(bus.armed), 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        run_frame("post-reset", all_min, 1'b0, dummy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
